hpi_bus_master: RTL and testbench

Parametrised RTL master for the CY7C67200 OTG Host Port Interface (HPI). It replaces software bit-banging of the otg_hpi_* PIO exports with a queued, timing-programmable read/write engine. Upstream logic pushes commands through a valid/ready queue, and read results return on a valid/ready response port. The block adds a controlled chip-reset sequence. It sits between the system (CPU bridge or a hardware keyboard poller) and the top-level HPI pins.

---
 rtl/hpi_pkg.sv | 33 +++
 rtl/hpi_cmd_fifo.sv | 50 +++++
 rtl/hpi_bus_master.sv | 171 +++++++++++++++++
 tb/tb_hpi_bus_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared types for the CY7C67200 HPI bus master.
// State encoding, command bundle and a small sizing helper.
package hpi_pkg;

    localparam int HPI_DATA_W = 16;
    localparam int HPI_ADDR_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP,
        CHIP_RST
    } hpi_state_t;

    typedef struct packed {
        logic                  write;
        logic [HPI_ADDR_W-1:0] addr;
        logic [HPI_DATA_W-1:0] wdata;
    } hpi_cmd_t;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hpi_cmd_fifo.sv
// Show-ahead command queue for the HPI master.
// Full/empty flags are registered so cmd_ready never depends on a pop.
module hpi_cmd_fifo
    import hpi_pkg::*;
#(
    parameter type T     = hpi_cmd_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  T              din,
    input  logic          rd,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt_n;

    assign cnt_n = count + CW'(wr) - CW'(rd);
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            count <= cnt_n;
            full  <= (cnt_n == CW'(DEPTH));
            empty <= (cnt_n == '0);
        end
    end

endmodule

// File: rtl/hpi_bus_master.sv
// Queued, timing-programmable read/write engine for the HPI pins.
// Every output is registered from the next-state decode.
module hpi_bus_master
    import hpi_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_CYC  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              chip_reset_req,
    output logic              busy,
    output logic [ADDR_W-1:0] otg_hpi_address_export,
    output logic              otg_hpi_cs_export,
    output logic              otg_hpi_r_export,
    output logic              otg_hpi_w_export,
    output logic              otg_hpi_reset_export,
    output logic [DATA_W-1:0] otg_hpi_data_out_port,
    output logic              otg_hpi_data_oe,
    input  logic [DATA_W-1:0] otg_hpi_data_in_port
);

    localparam int CNT_MAX = max4(SETUP_CYC, STROBE_CYC,
                                  HOLD_CYC, RESET_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FAW     = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    hpi_state_t   state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic         pend, pend_n;
    logic         dir, dir_n;
    logic         push, pop;
    logic         fifo_full, fifo_empty;
    logic [FAW:0] fifo_cnt, lvl_n;
    logic         active_n;
    cmd_t         in_cmd, head;

    assign in_cmd    = {cmd_write, cmd_addr, cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    hpi_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .wr    (push),
        .din   (in_cmd),
        .rd    (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        dir_n   = dir;
        pend_n  = pend | chip_reset_req;
        unique case (state)
            IDLE: begin
                if (pend) begin
                    state_n = CHIP_RST;
                    cnt_n   = CNT_W'(RESET_CYC - 1);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    dir_n   = head.write;
                    state_n = SETUP;
                    cnt_n   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = STROBE;
                    cnt_n   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) state_n = dir ? IDLE : RESP;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            CHIP_RST: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    pend_n  = chip_reset_req;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign lvl_n    = fifo_cnt + (FAW+1)'(push) - (FAW+1)'(pop);
    assign active_n = (state_n == SETUP) || (state_n == STROBE)
                   || (state_n == HOLD);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state                  <= IDLE;
            cnt                    <= '0;
            pend                   <= 1'b0;
            dir                    <= 1'b0;
            otg_hpi_cs_export      <= 1'b1;
            otg_hpi_r_export       <= 1'b1;
            otg_hpi_w_export       <= 1'b1;
            otg_hpi_reset_export   <= 1'b1;
            otg_hpi_data_oe        <= 1'b0;
            otg_hpi_address_export <= '0;
            otg_hpi_data_out_port  <= '0;
            rsp_valid              <= 1'b0;
            rsp_rdata              <= '0;
            busy                   <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            pend                 <= pend_n;
            dir                  <= dir_n;
            otg_hpi_cs_export    <= !active_n;
            otg_hpi_r_export     <= !((state_n == STROBE) && !dir_n);
            otg_hpi_w_export     <= !((state_n == STROBE) && dir_n);
            otg_hpi_reset_export <= (state_n != CHIP_RST);
            otg_hpi_data_oe      <= active_n && dir_n;
            rsp_valid            <= (state_n == RESP);
            busy <= (state_n != IDLE) || (lvl_n != '0) || pend_n;
            if (pop) begin
                otg_hpi_address_export <= head.addr;
                if (head.write) otg_hpi_data_out_port <= head.wdata;
            end
            // last strobe cycle: the pad data is valid here
            if ((state == STROBE) && (cnt == '0) && !dir)
                rsp_rdata <= otg_hpi_data_in_port;
        end
    end

endmodule

// File: tb/tb_hpi_bus_master.sv
// Directed bench for hpi_bus_master: default timing plus a
// second instance with stretched setup/strobe/hold.
module tb_hpi_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid6;
    logic        cmd_write;
    logic [1:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_ready;
    logic        chip_reset_req;
    logic [15:0] data_in;

    logic        cmd_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata, dout;
    logic [1:0]  addr;
    logic        cs, r, w, rst, oe;

    logic        cmd_ready6, rsp_valid6, busy6;
    logic [15:0] rsp_rdata6, dout6;
    logic [1:0]  addr6;
    logic        cs6, r6, w6, rst6, oe6;

    int total = 0;
    int bad   = 0;
    logic six = 1'b0;

    logic       h [0:5][0:63];
    logic [1:0] a_h [0:63];
    logic [15:0] d_h [0:63];

    always #5 clk = ~clk;

    hpi_bus_master u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .chip_reset_req(chip_reset_req), .busy(busy),
        .otg_hpi_address_export(addr), .otg_hpi_cs_export(cs),
        .otg_hpi_r_export(r), .otg_hpi_w_export(w),
        .otg_hpi_reset_export(rst), .otg_hpi_data_out_port(dout),
        .otg_hpi_data_oe(oe), .otg_hpi_data_in_port(data_in)
    );

    hpi_bus_master #(
        .SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)
    ) u_dut6 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid6),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata6),
        .chip_reset_req(chip_reset_req), .busy(busy6),
        .otg_hpi_address_export(addr6), .otg_hpi_cs_export(cs6),
        .otg_hpi_r_export(r6), .otg_hpi_w_export(w6),
        .otg_hpi_reset_export(rst6), .otg_hpi_data_out_port(dout6),
        .otg_hpi_data_oe(oe6), .otg_hpi_data_in_port(data_in)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int k);
        h[0][k] = six ? cs6  : cs;
        h[1][k] = six ? r6   : r;
        h[2][k] = six ? w6   : w;
        h[3][k] = six ? rst6 : rst;
        h[4][k] = six ? oe6  : oe;
        h[5][k] = six ? rsp_valid6 : rsp_valid;
        a_h[k]  = six ? addr6 : addr;
        d_h[k]  = six ? dout6 : dout;
    endtask

    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            snap(k);
        end
    endtask

    function automatic int nlow(input int s, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (!h[s][k]) c++;
        return c;
    endfunction

    function automatic int first_low(input int s, input int n);
        for (int k = 1; k <= n; k++) if (!h[s][k]) return k;
        return -1;
    endfunction

    task automatic push(input logic wr, input logic [1:0] a,
                        input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_valid6 = 1'b0;
        cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; chip_reset_req = 1'b0; data_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // reset state
        check("rst_cs", {cs, r, w, rst}, 4'hF);
        check("rst_oe_rv_busy", {oe, rsp_valid, busy}, 3'b000);
        check("rst_buses", {addr, dout, rsp_rdata}, 34'h0);
        check("rst_ready", cmd_ready, 1'b1);

        // 1: single write
        push(1'b1, 2'd2, 16'h1234);
        run(15);
        check("wr_cs_low", nlow(0, 15), 4);
        check("wr_w_low", nlow(2, 15), 2);
        check("wr_w_delay", first_low(2, 15) - first_low(0, 15), 1);
        check("wr_oe_high", 15 - nlow(4, 15), 4);
        check("wr_addr", a_h[1], 2);
        check("wr_data", d_h[1], 16'h1234);
        check("wr_no_r", nlow(1, 15), 0);
        check("wr_no_rsp", nlow(5, 15), 15);
        check("wr_busy_end", busy, 1'b0);

        // 2: read with consumer backpressure
        data_in = 16'hBEEF;
        push(1'b0, 2'd0, 16'h0);
        run(15);
        check("rd_r_low", nlow(1, 15), 2);
        check("rd_cs_low", nlow(0, 15), 4);
        check("rd_rv_cycles", 15 - nlow(5, 15), 11);
        check("rd_oe", 15 - nlow(4, 15), 0);
        data_in = 16'h0000;
        tick();
        check("rd_rdata_held", rsp_rdata, 16'hBEEF);
        check("rd_rv_held", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_rv_drop", rsp_valid, 1'b0);

        // 3: fill queue while stalled in RESP
        push(1'b0, 2'd1, 16'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check("st_rsp_seen", rsp_valid, 1'b1);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 2'(i);
            cmd_wdata = 16'(i);
            if (i == 4) check("st_ready_5th", cmd_ready, 1'b0);
            if (cmd_ready) acc++;
            tick();
        end
        check("st_accepted", acc, 4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("st_ready_after_rsp", cmd_ready, 1'b0);
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        check("st_pop_wait", n, 1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("st_drained", busy, 1'b0);
        check("st_last_wdata", dout, 16'h0004);

        // 4: chip reset requested mid-write, read queued
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 2'd1; cmd_wdata = 16'hA5A5;
        tick();
        cmd_write = 1'b0; cmd_addr = 2'd3; cmd_wdata = 16'h0;
        data_in = 16'h5A5A;
        for (int k = 1; k <= 30; k++) begin
            tick();
            snap(k);
            if (k == 1) cmd_valid = 1'b0;
            if (k == 2) chip_reset_req = 1'b1;
            if (k == 3) chip_reset_req = 1'b0;
        end
        check("cr_w_first", first_low(2, 30), 2);
        check("cr_w_low", nlow(2, 30), 2);
        check("cr_rst_first", first_low(3, 30), 6);
        check("cr_rst_low", nlow(3, 30), 8);
        check("cr_cs_low", nlow(0, 30), 8);
        check("cr_gap", {h[0][4], h[0][5], h[0][14], h[0][15]}, 4'b0110);
        check("cr_addrs", {a_h[1], a_h[15]}, 4'b0111);
        check("cr_r_first", first_low(1, 30), 16);
        check("cr_rdata", rsp_rdata, 16'h5A5A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: async reset during a read strobe
        push(1'b0, 2'd2, 16'h0);
        push(1'b1, 2'd1, 16'h0007);
        n = 0;
        while (r && n < 20) begin tick(); n++; end
        check("ar_strobe_seen", r, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pins", {cs, r, w, rst, oe}, 5'b11110);
        check("ar_rv_busy", {rsp_valid, busy}, 2'b00);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("ar_ready", cmd_ready, 1'b1);
        check("ar_busy", busy, 1'b0);
        run(6);
        check("ar_queue_empty", nlow(0, 6), 0);

        // 6: stretched timing, two back-to-back writes
        six = 1'b1;
        cmd_valid6 = 1'b1; cmd_write = 1'b1;
        cmd_addr = 2'd2; cmd_wdata = 16'h1111;
        tick();
        cmd_wdata = 16'h2222;
        for (int k = 1; k <= 30; k++) begin
            tick();
            snap(k);
            if (k == 1) cmd_valid6 = 1'b0;
        end
        check("t6_cs_low", nlow(0, 30), 18);
        check("t6_w_low", nlow(2, 30), 8);
        check("t6_w_first", first_low(2, 30), 4);
        check("t6_gap", {h[0][9], h[0][10], h[0][11], h[0][19], h[0][20]},
              5'b01001);
        check("t6_data2", d_h[15], 16'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
